// File: rtl/hazard_ctrl.sv
// Hazard sequencer: load-use, branch/jump flush, mult/div EX occupancy.
// Optional HAZARD_STATS_EN adds stall_cycles / flush_events counters.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       MemRead_EX,
  input  logic [4:0] rt_EX,
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       UseRt_ID,
  input  logic       Jump_ID,
  input  logic       BranchTaken_EX,
  input  logic       MulDiv_EX,
  output logic       stall_PC,
  output logic       stall_IFID,
  output logic       flush_IFID,
  output logic       stall_IDEX,
  output logic       flush_IDEX,
  output logic       flush_EXMEM,
  output logic       md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state;
  logic   [CNT_W-1:0] cnt;
  logic               load_use;
  logic               cnt_zero;

  assign load_use = MemRead_EX && (rt_EX != 5'd0) &&
                    ((rt_EX == rs_ID) ||
                     (UseRt_ID && (rt_EX == rt_ID)));
  assign cnt_zero = (cnt == '0);

  always_comb begin
    stall_PC    = 1'b0;
    stall_IFID  = 1'b0;
    flush_IFID  = 1'b0;
    stall_IDEX  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_EXMEM = 1'b0;
    md_busy     = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (BranchTaken_EX) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
          end else if (MulDiv_EX) begin
            stall_PC    = 1'b1;
            stall_IFID  = 1'b1;
            stall_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
          end else if (load_use) begin
            // jump flush waits until the bubble has been taken
            stall_PC   = 1'b1;
            stall_IFID = 1'b1;
            flush_IDEX = 1'b1;
          end else if (Jump_ID) begin
            flush_IFID = 1'b1;
          end
        end
        BUSY: begin
          md_busy = 1'b1;
          if (!cnt_zero) begin
            stall_PC    = 1'b1;
            stall_IFID  = 1'b1;
            stall_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!BranchTaken_EX && MulDiv_EX) begin
            state <= BUSY;
            cnt   <= CNT_W'(MD_LATENCY - 2);
          end
        end
        BUSY: begin
          if (cnt_zero) state <= IDLE;
          else          cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_PC)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_IFID || flush_IDEX)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MD_LATENCY=4).
// Output vector: {sPC,sIFID,fIFID,sIDEX,fIDEX,fEXMEM,busy}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       MemRead_EX;
  logic [4:0] rt_EX;
  logic [4:0] rs_ID;
  logic [4:0] rt_ID;
  logic       UseRt_ID;
  logic       Jump_ID;
  logic       BranchTaken_EX;
  logic       MulDiv_EX;
  logic       stall_PC;
  logic       stall_IFID;
  logic       flush_IFID;
  logic       stall_IDEX;
  logic       flush_IDEX;
  logic       flush_EXMEM;
  logic       md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif
  logic [6:0] outs;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemRead_EX     (MemRead_EX),
    .rt_EX          (rt_EX),
    .rs_ID          (rs_ID),
    .rt_ID          (rt_ID),
    .UseRt_ID       (UseRt_ID),
    .Jump_ID        (Jump_ID),
    .BranchTaken_EX (BranchTaken_EX),
    .MulDiv_EX      (MulDiv_EX),
    .stall_PC       (stall_PC),
    .stall_IFID     (stall_IFID),
    .flush_IFID     (flush_IFID),
    .stall_IDEX     (stall_IDEX),
    .flush_IDEX     (flush_IDEX),
    .flush_EXMEM    (flush_EXMEM),
    .md_busy        (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
`endif
  );

  assign outs = {stall_PC, stall_IFID, flush_IFID,
                 stall_IDEX, flush_IDEX,
                 flush_EXMEM, md_busy};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic step(input string tag,
                      input logic rst,
                      input logic mr,
                      input logic [4:0] rte,
                      input logic [4:0] rsi,
                      input logic [4:0] rti,
                      input logic urt,
                      input logic j,
                      input logic br,
                      input logic md,
                      input logic [6:0] exp);
    @(negedge clk);
    reset          = rst;
    MemRead_EX     = mr;
    rt_EX          = rte;
    rs_ID          = rsi;
    rt_ID          = rti;
    UseRt_ID       = urt;
    Jump_ID        = j;
    BranchTaken_EX = br;
    MulDiv_EX      = md;
    #1;
    check(tag, {25'd0, outs}, {25'd0, exp});
  endtask

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] JMP  = 7'b0010000;
  localparam logic [6:0] BR   = 7'b0010100;
  localparam logic [6:0] MD0  = 7'b1101010;
  localparam logic [6:0] MDB  = 7'b1101011;
  localparam logic [6:0] REL  = 7'b0000001;

  initial begin
    reset = 1'b1;
    MemRead_EX = 0; rt_EX = 0; rs_ID = 0; rt_ID = 0;
    UseRt_ID = 0; Jump_ID = 0;
    BranchTaken_EX = 0; MulDiv_EX = 0;

    step("rst_hold", 1, 1, 8, 8, 8, 1, 1, 1, 1, NONE);
    step("rst_md",   1, 0, 0, 0, 0, 0, 0, 0, 1, NONE);
    step("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    step("lu_rs",    0, 1, 8, 8, 0, 0, 0, 0, 0, LU);
    step("lu_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    step("lu_r0",    0, 1, 0, 0, 0, 1, 0, 0, 0, NONE);
    step("lu_nort",  0, 1, 8, 3, 8, 0, 0, 0, 0, NONE);
    step("lu_rt",    0, 1, 8, 3, 8, 1, 0, 0, 0, LU);
    step("lu_nold",  0, 0, 8, 8, 8, 1, 0, 0, 0, NONE);

    step("jmp",      0, 0, 0, 0, 0, 0, 1, 0, 0, JMP);
    step("jmp_lu",   0, 1, 9, 9, 0, 0, 1, 0, 0, LU);
    step("jmp_post", 0, 0, 0, 0, 0, 0, 1, 0, 0, JMP);

    step("md_c1",    0, 0, 0, 0, 0, 0, 0, 0, 1, MD0);
    step("md_c2",    0, 0, 0, 0, 0, 0, 1, 0, 1, MDB);
    step("md_c3",    0, 1, 8, 8, 0, 0, 0, 1, 1, MDB);
    step("md_c4",    0, 0, 0, 0, 0, 0, 0, 0, 1, REL);
    step("md2_c1",   0, 0, 0, 0, 0, 0, 0, 0, 1, MD0);
    step("md2_c2",   0, 0, 0, 0, 0, 0, 0, 0, 1, MDB);
    step("md2_c3",   0, 0, 0, 0, 0, 0, 0, 0, 1, MDB);
    step("md2_c4",   0, 0, 0, 0, 0, 0, 0, 0, 1, REL);
    step("md_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    step("br_all",   0, 1, 8, 8, 0, 0, 1, 1, 0, BR);
    step("br_md",    0, 0, 0, 0, 0, 0, 0, 1, 1, BR);
    step("br_next",  0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    step("mdlw_c1",  0, 1, 8, 8, 0, 0, 0, 0, 1, MD0);
    step("mdlw_c2",  0, 0, 0, 0, 0, 0, 0, 0, 1, MDB);
    step("rst_busy", 1, 0, 0, 0, 0, 0, 0, 0, 1, NONE);
    step("rst_aft1", 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    step("rst_aft2", 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

`ifdef HAZARD_STATS_EN
    step("st_rst",   1, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    check("st_stall0", stall_cycles, 32'd0);
    check("st_flush0", flush_events, 32'd0);
    step("st_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    step("st_lu",    0, 1, 8, 8, 0, 0, 0, 0, 0, LU);
    step("st_lu2",   0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    step("st_md1",   0, 0, 0, 0, 0, 0, 0, 0, 1, MD0);
    step("st_md2",   0, 0, 0, 0, 0, 0, 0, 0, 1, MDB);
    step("st_md3",   0, 0, 0, 0, 0, 0, 0, 0, 1, MDB);
    step("st_md4",   0, 0, 0, 0, 0, 0, 0, 0, 1, REL);
    step("st_br",    0, 1, 8, 8, 0, 0, 1, 1, 0, BR);
    step("st_end",   0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    check("st_stall", stall_cycles, 32'd4);
    check("st_flush", flush_events, 32'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
